// File: rtl/prio_rr_arbiter.sv
// Priority arbiter with round-robin tie breaking among equal-priority requesters.
// Registered one-hot grant, optionally locked until the grantee releases it.
module prio_rr_arbiter #(
  parameter int N         = 8,
  parameter int PRIO_BITS = 3,
  parameter int LOCK      = 1,
  localparam int SW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [N-1:0]           req_i,
  input  logic [N*PRIO_BITS-1:0] prio_i,
  input  logic                   done_i,
  output logic [N-1:0]           gnt_o,
  output logic                   gnt_valid_o,
  output logic [SW-1:0]          sel_o,
  output logic [PRIO_BITS-1:0]   prio_o
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                 state_q, state_d;
  logic [N-1:0]           gnt_q, gnt_d;
  logic [SW-1:0]          sel_q, sel_d;
  logic [PRIO_BITS-1:0]   prio_q, prio_d;
  logic [SW-1:0]          last_q, last_d;

  logic [PRIO_BITS-1:0]   prio_arr [N];
  logic [PRIO_BITS-1:0]   min_prio;
  logic                   any_req;
  logic                   win_found;
  logic [SW-1:0]          win_idx;
  logic [SW:0]            rr_sum;
  logic [SW-1:0]          rr_idx;
  logic                   issue;
  logic                   drop;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      prio_arr[k] = prio_i[k*PRIO_BITS +: PRIO_BITS];
    end
  end

  // Winner: lowest priority value, ties resolved starting just after last grant
  always_comb begin
    any_req   = |req_i;
    min_prio  = '1;
    for (int k = 0; k < N; k++) begin
      if (req_i[k] && (prio_arr[k] < min_prio)) min_prio = prio_arr[k];
    end
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int i = 0; i < N; i++) begin
      rr_sum = {1'b0, last_q} + (SW+1)'(i + 1);
      if (rr_sum >= (SW+1)'(N)) rr_sum = rr_sum - (SW+1)'(N);
      rr_idx = rr_sum[SW-1:0];
      if (!win_found && req_i[rr_idx] && (prio_arr[rr_idx] == min_prio)) begin
        win_found = 1'b1;
        win_idx   = rr_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    last_d  = last_q;
    issue   = 1'b0;
    drop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        issue = any_req;
      end
      S_GRANT: begin
        if ((LOCK == 0) || done_i || !req_i[sel_q]) begin
          issue = any_req;
          drop  = !any_req;
        end
      end
      default: drop = 1'b1;
    endcase
    if (issue) begin
      state_d = S_GRANT;
      gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
      sel_d   = win_idx;
      prio_d  = min_prio;
      last_d  = win_idx;
    end else if (drop) begin
      state_d = S_IDLE;
      gnt_d   = '0;
    end
  end

  // Grant register stage; sel/prio hold across idle
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      prio_q  <= '0;
      last_q  <= SW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      last_q  <= last_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = (state_q == S_GRANT);
  assign sel_o       = sel_q;
  assign prio_o      = prio_q;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed and randomized checks for prio_rr_arbiter: N=8 locked and N=5 unlocked.
module tb_prio_rr_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  req_a;
  logic [23:0] prio_a;
  logic        done_a;
  logic [7:0]  gnt_a;
  logic        vld_a;
  logic [2:0]  sel_a;
  logic [2:0]  pri_a;

  logic [4:0]  req_b;
  logic [14:0] prio_b;
  logic        done_b;
  logic [4:0]  gnt_b;
  logic        vld_b;
  logic [2:0]  sel_b;
  logic [2:0]  pri_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prio_rr_arbiter #(.N(8), .PRIO_BITS(3), .LOCK(1)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .req_i(req_a), .prio_i(prio_a), .done_i(done_a),
    .gnt_o(gnt_a), .gnt_valid_o(vld_a), .sel_o(sel_a), .prio_o(pri_a)
  );

  prio_rr_arbiter #(.N(5), .PRIO_BITS(3), .LOCK(0)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .req_i(req_b), .prio_i(prio_b), .done_i(done_b),
    .gnt_o(gnt_b), .gnt_valid_o(vld_b), .sel_o(sel_b), .prio_o(pri_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0; req_a = '0; done_a = 1'b0; req_b = '0; done_b = 1'b0;
    prio_a = {8{3'd7}}; prio_b = {5{3'd7}};
    tick;
    rstn = 1'b1;
  endtask

  task automatic check_a(input string name, input logic v, input logic [7:0] g,
                         input logic [2:0] s, input logic [2:0] p);
    checks++;
    if ({vld_a, gnt_a, sel_a, pri_a} !== {v, g, s, p}) begin
      failures++;
      $display("FAIL %s: got vld=%0b gnt=%02h sel=%0d prio=%0d, expected vld=%0b gnt=%02h sel=%0d prio=%0d",
               name, vld_a, gnt_a, sel_a, pri_a, v, g, s, p);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; req_a = 8'hFF; done_a = 1'b0; req_b = '1; done_b = 1'b0;
    prio_a = '0; prio_b = '0;
    tick; tick;
    check_a("reset_a", 1'b0, 8'h00, 3'd0, 3'd0);
    checks++;
    if ({vld_b, gnt_b, sel_b, pri_b} !== 12'h000) begin
      failures++;
      $display("FAIL reset_b: got vld=%0b gnt=%02h sel=%0d prio=%0d, expected all zero", vld_b, gnt_b, sel_b, pri_b);
    end
  endtask

  task automatic test_basic;
    do_reset;
    prio_a[2*3 +: 3] = 3'd3; prio_a[5*3 +: 3] = 3'd1;
    req_a = 8'h24;
    tick;
    check_a("basic_grant", 1'b1, 8'h20, 3'd5, 3'd1);
    req_a = 8'h00;
    tick;
    check_a("basic_idle_hold", 1'b0, 8'h00, 3'd5, 3'd1);
  endtask

  task automatic test_tie_rotation;
    do_reset;
    prio_a = {8{3'd2}};
    req_a = 8'hFF;
    tick;
    check_a("rot_first", 1'b1, 8'h01, 3'd0, 3'd2);
    done_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      check_a($sformatf("rot_%0d", i), 1'b1, 8'h01 << (i % 8), 3'(i % 8), 3'd2);
    end
    done_a = 1'b0; req_a = 8'h00;
    tick;
  endtask

  task automatic test_lock;
    do_reset;
    prio_a[3*3 +: 3] = 3'd4;
    req_a = 8'h08;
    tick;
    check_a("lock_grant3", 1'b1, 8'h08, 3'd3, 3'd4);
    prio_a[1*3 +: 3] = 3'd0;
    req_a = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_a($sformatf("lock_hold_%0d", i), 1'b1, 8'h08, 3'd3, 3'd4);
    end
    prio_a[3*3 +: 3] = 3'd6;
    tick;
    check_a("lock_prio_frozen", 1'b1, 8'h08, 3'd3, 3'd4);
    done_a = 1'b1;
    tick;
    check_a("lock_release", 1'b1, 8'h02, 3'd1, 3'd0);
    done_a = 1'b0; req_a = 8'h00;
    tick;
  endtask

  task automatic test_back_to_back;
    do_reset;
    prio_a[2*3 +: 3] = 3'd2;
    req_a = 8'h04;
    tick;
    check_a("b2b_first", 1'b1, 8'h04, 3'd2, 3'd2);
    done_a = 1'b1;
    tick;
    check_a("b2b_regrant_self", 1'b1, 8'h04, 3'd2, 3'd2);
    prio_a[6*3 +: 3] = 3'd2; req_a = 8'h44;
    tick;
    check_a("b2b_to6", 1'b1, 8'h40, 3'd6, 3'd2);
    tick;
    check_a("b2b_wrap2", 1'b1, 8'h04, 3'd2, 3'd2);
    done_a = 1'b0; req_a = 8'h00;
    tick;
    check_a("b2b_idle", 1'b0, 8'h00, 3'd2, 3'd2);
  endtask

  task automatic test_drop;
    do_reset;
    prio_a[6*3 +: 3] = 3'd5;
    req_a = 8'h40;
    tick;
    check_a("drop_grant6", 1'b1, 8'h40, 3'd6, 3'd5);
    req_a = 8'h00;
    tick;
    check_a("drop_idle", 1'b0, 8'h00, 3'd6, 3'd5);
    req_a = 8'h01;
    tick;
    check_a("drop_new0", 1'b1, 8'h01, 3'd0, 3'd7);
    req_a = 8'h00;
    tick;
  endtask

  task automatic test_reset_mid;
    do_reset;
    prio_a[4*3 +: 3] = 3'd1;
    req_a = 8'h10;
    tick;
    check_a("rmid_grant4", 1'b1, 8'h10, 3'd4, 3'd1);
    rstn = 1'b0;
    tick;
    check_a("rmid_dropped", 1'b0, 8'h00, 3'd0, 3'd0);
    rstn = 1'b1; req_a = 8'hFF; prio_a = {8{3'd3}};
    tick;
    check_a("rmid_first0", 1'b1, 8'h01, 3'd0, 3'd3);
    req_a = 8'h00;
    tick;
  endtask

  task automatic test_unlocked;
    logic [2:0] exp_sel, exp_pri, mn;
    logic       exp_v, found;
    int         last_m, idx;
    do_reset;
    prio_b = {5{3'd3}};
    req_b = 5'b10010; done_b = 1'b0;
    tick;
    checks++;
    if (sel_b !== 3'd1 || vld_b !== 1'b1) begin
      failures++; $display("FAIL nolock_first: got sel=%0d vld=%0b, expected sel=1 vld=1", sel_b, vld_b);
    end
    tick;
    checks++;
    if (sel_b !== 3'd4 || gnt_b !== 5'b10000) begin
      failures++; $display("FAIL nolock_rearb: got sel=%0d gnt=%02h, expected sel=4 gnt=10", sel_b, gnt_b);
    end
    done_b = 1'b1;
    tick;
    checks++;
    if (sel_b !== 3'd1 || gnt_b !== 5'b00010) begin
      failures++; $display("FAIL nolock_wrap: got sel=%0d gnt=%02h, expected sel=1 gnt=02", sel_b, gnt_b);
    end
    do_reset;
    last_m = 4; exp_sel = 3'd0; exp_pri = 3'd0;
    for (int c = 0; c < 150; c++) begin
      req_b  = 5'($urandom_range(0, 31));
      done_b = 1'($urandom_range(0, 1));
      for (int k = 0; k < 5; k++) prio_b[k*3 +: 3] = 3'($urandom_range(0, 7));
      mn = 3'd7;
      for (int k = 0; k < 5; k++) if (req_b[k] && prio_b[k*3 +: 3] < mn) mn = prio_b[k*3 +: 3];
      exp_v = (req_b != 5'd0);
      found = 1'b0;
      for (int off = 1; off <= 5; off++) begin
        idx = (last_m + off) % 5;
        if (!found && req_b[idx] && prio_b[idx*3 +: 3] == mn) begin
          found = 1'b1; exp_sel = 3'(idx); exp_pri = mn; last_m = idx;
        end
      end
      tick;
      checks++;
      if (vld_b !== exp_v || sel_b !== exp_sel || pri_b !== exp_pri ||
          gnt_b !== (exp_v ? (5'b00001 << exp_sel) : 5'b00000) || sel_b > 3'd4) begin
        failures++;
        $display("FAIL nolock_rand_%0d: got vld=%0b gnt=%02h sel=%0d prio=%0d, expected vld=%0b sel=%0d prio=%0d",
                 c, vld_b, gnt_b, sel_b, pri_b, exp_v, exp_sel, exp_pri);
      end
    end
    req_b = '0; done_b = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_tie_rotation;
    test_lock;
    test_back_to_back;
    test_drop;
    test_reset_mid;
    test_unlocked;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
